// File: rtl/s2p_load_scheduler_pkg.sv
// Shared types for the seq2parallel load scheduler: lane-state encoding,
// the per-beat tag carried down the read-latency pipe, and arbitration helpers.
package s2p_load_scheduler_pkg;

    localparam int KERNEL_WIDTH = 3;   // words per parallel row
    localparam int DATA_WIDTH   = 16;  // SRAM word width

    typedef enum logic [2:0] {
        LANE_IDLE  = 3'd0,
        LANE_REQ   = 3'd1,
        LANE_FETCH = 3'd2,
        LANE_FULL  = 3'd3,
        LANE_FIN   = 3'd4
    } lane_state_e;

    // One entry per SRAM read beat, delayed by the read latency so that
    // begin_serial and fill_done line up with data on in_serial.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic lane;
    } beat_tag_t;

    // Round-robin pick: the pointer only matters when both lanes ask.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        if (req == 2'b11) return ptr;
        return req[1];
    endfunction

    function automatic logic [1:0] lane_onehot(input logic lane);
        return lane ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/s2p_load_scheduler_if.sv
// Job configuration, PE row requests, SRAM read port and seq2parallel controls.
// master = scheduler side, slave = surrounding datapath side.
interface s2p_load_scheduler_if #(
    parameter int ADDR_W = 12,
    parameter int ROW_W  = 8
);
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_act_base;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic [ROW_W-1:0]  cfg_rows;
    logic [1:0]        row_req;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        begin_serial;
    logic [1:0]        refresh;
    logic              busy;
    logic              done;

    modport master (
        input  cfg_start, cfg_act_base, cfg_wgt_base, cfg_rows, row_req,
        output rd_en, rd_addr, begin_serial, refresh, busy, done
    );

    modport slave (
        output cfg_start, cfg_act_base, cfg_wgt_base, cfg_rows, row_req,
        input  rd_en, rd_addr, begin_serial, refresh, busy, done
    );
endinterface

// File: rtl/s2p_lane_fsm.sv
// Per-lane sequencer: requests the read port, waits for the shadow register
// to fill, then hands the row to the PE on row_req and counts rows.
module s2p_lane_fsm
    import s2p_load_scheduler_pkg::*;
#(
    parameter int NUM    = KERNEL_WIDTH,
    parameter int ADDR_W = 12,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,      // job start with a non-zero row count
    input  logic [ADDR_W-1:0] base,
    input  logic [ROW_W-1:0]  rows,
    input  logic              grant,
    input  logic              addr_adv,   // last beat of this lane's burst
    input  logic              fill_done,  // last word lands in the shadow register
    input  logic              row_req,
    input  logic              clear,      // job done, return to IDLE
    output logic              req,
    output logic              refresh,
    output lane_state_e       state,
    output logic [ADDR_W-1:0] lane_addr
);

    lane_state_e       state_nxt;
    logic [ROW_W-1:0]  row_cnt, row_cnt_nxt, row_inc;
    logic [ADDR_W-1:0] lane_addr_nxt;

    assign row_inc = row_cnt + ROW_W'(1);

    // State, row counter and fetch address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LANE_IDLE;
            row_cnt   <= '0;
            lane_addr <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            lane_addr <= lane_addr_nxt;
        end
    end

    // Next-state and request/refresh decode.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_nxt     = state;
        row_cnt_nxt   = row_cnt;
        lane_addr_nxt = lane_addr;
        req           = 1'b0;
        refresh       = 1'b0;
        case (state)
            LANE_IDLE: begin
                if (start) begin
                    state_nxt     = LANE_REQ;
                    row_cnt_nxt   = '0;
                    lane_addr_nxt = base;
                end
            end
            LANE_REQ: begin
                req = 1'b1;
                if (grant) state_nxt = LANE_FETCH;
            end
            LANE_FETCH: begin
                if (fill_done) state_nxt = LANE_FULL;
            end
            LANE_FULL: begin
                // row_req is a level, so a request raised earlier simply waits here.
                if (row_req) begin
                    refresh     = 1'b1;
                    row_cnt_nxt = row_inc;
                    state_nxt   = (row_inc < rows) ? LANE_REQ : LANE_FIN;
                end
            end
            LANE_FIN: begin
                if (clear) state_nxt = LANE_IDLE;
            end
            default: state_nxt = LANE_IDLE;
        endcase
        // The address steps past the burst once its last beat has been issued.
        if (addr_adv) lane_addr_nxt = lane_addr + ADDR_W'(NUM);
    end

endmodule

// File: rtl/s2p_load_scheduler.sv
// Shares one SRAM read port and the in_serial bus between the activation
// (lane 0) and weight (lane 1) seq2parallel instances. Each grant issues an
// unstalled NUM-beat burst; begin_serial fires with the first returned word.
module s2p_load_scheduler
    import s2p_load_scheduler_pkg::*;
#(
    parameter int NUM    = KERNEL_WIDTH,
    parameter int ADDR_W = 12,
    parameter int ROW_W  = 8,
    parameter int RD_LAT = 1
) (
    input logic                   clk,
    input logic                   reset,
    s2p_load_scheduler_if.master  bus
);

    localparam int CNT_W = $clog2(NUM) + 1;

    logic              job_q, rr_ptr, burst_lane, start_job, lane_start, done, lanes_end;
    logic [ROW_W-1:0]  rows_q;
    logic [CNT_W-1:0]  burst_cnt;
    logic [ADDR_W-1:0] burst_addr, rd_addr_c;
    logic              grant_any, grant_lane;
    logic [1:0]        req, grant, refresh, addr_adv, fill_done, begin_c;
    lane_state_e       lane_state [2];
    logic [ADDR_W-1:0] lane_addr [2];
    beat_tag_t         cur_tag, out_tag;
    beat_tag_t         pipe [RD_LAT];

    // A cfg_start arriving while a job runs (including its done cycle) is dropped.
    assign start_job  = bus.cfg_start && !job_q;
    assign lane_start = start_job && (bus.cfg_rows != '0);
    assign lanes_end  = (lane_state[0] == LANE_IDLE || lane_state[0] == LANE_FIN) &&
                        (lane_state[1] == LANE_IDLE || lane_state[1] == LANE_FIN);
    assign done       = job_q && lanes_end;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        s2p_lane_fsm #(.NUM(NUM), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .start     (lane_start),
            .base      (l == 0 ? bus.cfg_act_base : bus.cfg_wgt_base),
            .rows      (rows_q),
            .grant     (grant[l]),
            .addr_adv  (addr_adv[l]),
            .fill_done (fill_done[l]),
            .row_req   (bus.row_req[l]),
            .clear     (done),
            .req       (req[l]),
            .refresh   (refresh[l]),
            .state     (lane_state[l]),
            .lane_addr (lane_addr[l])
        );
    end

    // Arbitration and current-beat decode; a grant only happens on an idle port.
    always_comb begin
        grant_any     = (burst_cnt == '0) && (req != 2'b00);
        grant_lane    = rr_pick(req, rr_ptr);
        grant         = grant_any ? lane_onehot(grant_lane) : 2'b00;
        cur_tag       = '0;
        cur_tag.valid = grant_any || (burst_cnt != '0);
        cur_tag.first = grant_any;
        cur_tag.last  = grant_any ? (NUM == 1) : (burst_cnt == CNT_W'(1));
        cur_tag.lane  = grant_any ? grant_lane : burst_lane;
        rd_addr_c     = grant_any ? lane_addr[grant_lane] :
                        ((burst_cnt != '0) ? burst_addr : '0);
        addr_adv      = (cur_tag.valid && cur_tag.last) ? lane_onehot(cur_tag.lane) : 2'b00;
    end

    // Job flag, latched row count, RR pointer and burst sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            job_q      <= 1'b0;
            rows_q     <= '0;
            rr_ptr     <= 1'b0;
            burst_cnt  <= '0;
            burst_lane <= 1'b0;
            burst_addr <= '0;
        end else begin
            if (start_job) begin
                job_q  <= 1'b1;
                rows_q <= bus.cfg_rows;
            end else if (done) begin
                job_q  <= 1'b0;
            end
            if (grant_any) begin
                burst_cnt  <= CNT_W'(NUM - 1);
                burst_lane <= grant_lane;
                burst_addr <= lane_addr[grant_lane] + ADDR_W'(1);
                rr_ptr     <= ~grant_lane;
            end else if (burst_cnt != '0) begin
                burst_cnt  <= burst_cnt - CNT_W'(1);
                burst_addr <= burst_addr + ADDR_W'(1);
            end
        end
    end

    // Delay beat tags by the SRAM read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this pipe is flops, so it is reset; a RAM-backed store would be left unreset.
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= cur_tag;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Align begin_serial and fill_done with the data returning on in_serial.
    always_comb begin
        out_tag   = pipe[RD_LAT-1];
        begin_c   = (out_tag.valid && out_tag.first) ? lane_onehot(out_tag.lane) : 2'b00;
        fill_done = (out_tag.valid && out_tag.last)  ? lane_onehot(out_tag.lane) : 2'b00;
    end

    assign bus.rd_en        = cur_tag.valid;
    assign bus.rd_addr      = rd_addr_c;
    assign bus.begin_serial = begin_c;
    assign bus.refresh      = refresh;
    assign bus.busy         = job_q && !done;
    assign bus.done         = done;

endmodule

// File: tb/tb_s2p_load_scheduler.sv
// Bench for s2p_load_scheduler with NUM=3, RD_LAT=1: an SRAM model feeding
// in_serial, two seq2parallel shadow models, and a queue-based scoreboard.
// Stimulus pushes expected (cycle, value) events; the monitor pops on each output event.
module tb_s2p_load_scheduler;
    import s2p_load_scheduler_pkg::*;

    localparam int NUM = 3;
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = 12;

    typedef struct { int cyc; logic [AW-1:0] addr; } rd_exp_t;
    typedef struct { int cyc; logic [1:0] val; } beg_exp_t;
    typedef struct { int cyc; logic [1:0] val; logic [NUM*DW-1:0] data; } ref_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    s2p_load_scheduler_if #(.ADDR_W(AW), .ROW_W(8)) bus ();

    s2p_load_scheduler #(.NUM(NUM), .ADDR_W(AW), .ROW_W(8), .RD_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rd_exp_t  rd_q [$];
    beg_exp_t beg_q [$];
    ref_exp_t ref_q [$];
    int       done_q [$];

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {4'hA, a};
    endfunction

    function automatic logic [NUM*DW-1:0] row_of(input logic [AW-1:0] b);
        logic [NUM*DW-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*DW +: DW] = word_of(b + AW'(k));
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // SRAM with one cycle of read latency.
    logic [DW-1:0] in_serial;
    always @(posedge clk or negedge reset) begin
        if (!reset) in_serial <= '0;
        else        in_serial <= bus.rd_en ? word_of(bus.rd_addr) : '0;
    end

    // seq2parallel shadow registers: begin captures word 0, then NUM-1 more beats.
    logic [NUM*DW-1:0] shadow [2];
    int beat [2];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                shadow[l] <= '0;
                beat[l]   <= 0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (bus.begin_serial[l]) begin
                    shadow[l][0 +: DW] <= in_serial;
                    beat[l] <= 1;
                end else if (beat[l] != 0) begin
                    shadow[l][beat[l]*DW +: DW] <= in_serial;
                    beat[l] <= (beat[l] == NUM - 1) ? 0 : beat[l] + 1;
                end
            end
        end
    end

    // Monitor: every output event must match the head of its queue.
    rd_exp_t  m_rd;
    beg_exp_t m_bg;
    ref_exp_t m_rf;
    int       m_dn;
    always @(negedge clk) begin
        if (bus.rd_en) begin
            if (rd_q.size() == 0) check("unexpected rd_en addr", 64'(bus.rd_addr), 64'hFFFF_FFFF);
            else begin
                m_rd = rd_q.pop_front();
                check("rd_en cycle", 64'(cyc), 64'(m_rd.cyc));
                check("rd_addr", 64'(bus.rd_addr), 64'(m_rd.addr));
            end
        end
        if (bus.begin_serial != 2'b00) begin
            if (beg_q.size() == 0) check("unexpected begin_serial", 64'(bus.begin_serial), 64'h0);
            else begin
                m_bg = beg_q.pop_front();
                check("begin_serial cycle", 64'(cyc), 64'(m_bg.cyc));
                check("begin_serial lane", 64'(bus.begin_serial), 64'(m_bg.val));
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (bus.refresh[l]) begin
                if (ref_q.size() == 0) check("unexpected refresh", 64'(bus.refresh), 64'h0);
                else begin
                    m_rf = ref_q.pop_front();
                    check("refresh cycle", 64'(cyc), 64'(m_rf.cyc));
                    check("refresh lane", 64'(lane_onehot(1'(l))), 64'(m_rf.val));
                    check("parallel row data", 64'(shadow[l]), 64'(m_rf.data));
                end
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) check("unexpected done", 64'(bus.done), 64'h0);
            else begin
                m_dn = done_q.pop_front();
                check("done cycle", 64'(cyc), 64'(m_dn));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int c, input logic [AW-1:0] a);
        rd_exp_t e;
        e.cyc = c; e.addr = a;
        rd_q.push_back(e);
    endtask

    task automatic push_beg(input int c, input logic [1:0] v);
        beg_exp_t e;
        e.cyc = c; e.val = v;
        beg_q.push_back(e);
    endtask

    task automatic push_ref(input int c, input logic [1:0] v, input logic [AW-1:0] b);
        ref_exp_t e;
        e.cyc = c; e.val = v; e.data = row_of(b);
        ref_q.push_back(e);
    endtask

    // Drives one cfg_start cycle; s is the cycle in which cfg_start is high.
    task automatic start_job(input logic [AW-1:0] act, input logic [AW-1:0] wgt,
                             input logic [7:0] rows, output int s);
        bus.cfg_act_base = act;
        bus.cfg_wgt_base = wgt;
        bus.cfg_rows     = rows;
        s = cyc;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    // Schedule with row_req held high on both lanes (hand-derived for NUM=3,
    // RD_LAT=1): lane0 granted at s+1+6r, lane1 at s+4+6r, begin one cycle
    // after grant, shadow full and refreshed 4 cycles after grant.
    task automatic expect_held(input int s, input logic [AW-1:0] act,
                               input logic [AW-1:0] wgt, input int rows);
        for (int r = 0; r < rows; r++) begin
            for (int k = 0; k < NUM; k++) push_rd(s + 1 + 6*r + k, act + AW'(3*r + k));
            for (int k = 0; k < NUM; k++) push_rd(s + 4 + 6*r + k, wgt + AW'(3*r + k));
            push_beg(s + 2 + 6*r, 2'b01);
            push_beg(s + 5 + 6*r, 2'b10);
            push_ref(s + 5 + 6*r, 2'b01, act + AW'(3*r));
            push_ref(s + 8 + 6*r, 2'b10, wgt + AW'(3*r));
        end
        done_q.push_back(s + 9 + 6*(rows - 1));
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while ((rd_q.size() + beg_q.size() + ref_q.size() + done_q.size()) != 0 && n < limit) begin
            tick();
            n++;
        end
        check({name, " pending events at timeout"},
              64'(rd_q.size() + beg_q.size() + ref_q.size() + done_q.size()), 64'h0);
        rd_q.delete(); beg_q.delete(); ref_q.delete(); done_q.delete();
        repeat (3) tick();
    endtask

    task automatic check_quiet(input string name);
        check(name, {bus.rd_en, bus.rd_addr, bus.begin_serial, bus.refresh, bus.busy, bus.done}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        bus.cfg_start    = 1'b0;
        bus.cfg_act_base = '0;
        bus.cfg_wgt_base = '0;
        bus.cfg_rows     = '0;
        bus.row_req      = 2'b11;

        repeat (2) tick();
        check_quiet("outputs in reset");
        reset = 1'b1;
        repeat (2) tick();
        check_quiet("outputs idle after reset");

        // 1: rows=1, lane0 then lane1 burst, one refresh each, done once.
        start_job(12'h010, 12'h100, 8'd1, s);
        expect_held(s, 12'h010, 12'h100, 1);
        check("busy after cfg_start", 64'(bus.busy), 64'h1);
        wait_idle("rows1", 40);
        check("busy after done", 64'(bus.busy), 64'h0);

        // 2: both lanes request together, two rows, port continuously busy.
        start_job(12'h200, 12'h300, 8'd2, s);
        expect_held(s, 12'h200, 12'h300, 2);
        wait_idle("rows2", 40);

        // 3: lane1 PE stalls; lane1 parks in FULL until row_req[1] rises at s+21.
        bus.row_req = 2'b01;
        start_job(12'h500, 12'h600, 8'd3, s);
        push_rd(s+1, 12'h500);  push_rd(s+2, 12'h501);  push_rd(s+3, 12'h502);
        push_rd(s+4, 12'h600);  push_rd(s+5, 12'h601);  push_rd(s+6, 12'h602);
        push_rd(s+7, 12'h503);  push_rd(s+8, 12'h504);  push_rd(s+9, 12'h505);
        push_rd(s+12, 12'h506); push_rd(s+13, 12'h507); push_rd(s+14, 12'h508);
        push_rd(s+22, 12'h603); push_rd(s+23, 12'h604); push_rd(s+24, 12'h605);
        push_rd(s+27, 12'h606); push_rd(s+28, 12'h607); push_rd(s+29, 12'h608);
        push_beg(s+2, 2'b01);  push_beg(s+5, 2'b10);  push_beg(s+8, 2'b01);
        push_beg(s+13, 2'b01); push_beg(s+23, 2'b10); push_beg(s+28, 2'b10);
        push_ref(s+5, 2'b01, 12'h500);  push_ref(s+11, 2'b01, 12'h503);
        push_ref(s+16, 2'b01, 12'h506); push_ref(s+21, 2'b10, 12'h600);
        push_ref(s+26, 2'b10, 12'h603); push_ref(s+31, 2'b10, 12'h606);
        done_q.push_back(s + 32);
        while (cyc < s + 20) tick();
        check("busy while lane1 parked", 64'(bus.busy), 64'h1);
        tick();
        bus.row_req = 2'b11;
        wait_idle("lane1 stall", 80);

        // 4: rows=0 completes in one cycle; cfg_start in the done cycle is ignored.
        start_job(12'h000, 12'h000, 8'd0, s);
        done_q.push_back(s + 1);
        check("busy low in done cycle", 64'(bus.busy), 64'h0);
        check("done in cycle after start", 64'(bus.done), 64'h1);
        bus.cfg_act_base = 12'h123;
        bus.cfg_rows     = 8'd1;
        bus.cfg_start    = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        repeat (12) tick();
        check("no job from start during done", 64'(bus.busy), 64'h0);
        wait_idle("rows0", 10);

        // 5: reset in the second read cycle, then a clean job from a new base.
        start_job(12'h040, 12'h050, 8'd1, s);
        push_rd(s + 1, 12'h040);
        tick();
        reset = 1'b0;
        #1;
        check_quiet("outputs at mid-burst reset");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        wait_idle("aborted job", 5);
        start_job(12'h080, 12'h090, 8'd1, s);
        expect_held(s, 12'h080, 12'h090, 1);
        wait_idle("after reset", 40);

        // 6: address wrap on lane0, cfg_start while busy has no effect.
        start_job(12'hFFE, 12'h400, 8'd2, s);
        expect_held(s, 12'hFFE, 12'h400, 2);
        tick();
        tick();
        bus.cfg_act_base = 12'h700;
        bus.cfg_wgt_base = 12'h710;
        bus.cfg_rows     = 8'd5;
        bus.cfg_start    = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        wait_idle("wrap", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
